// File: rtl/switch_pre.sv
// switch_pre: ingress pre-processor of the switch core.
// Packs a byte-serial MAC frame into 128-bit cells for the ingress cell
// data FIFO and, once the frame has ended, writes one 16-bit descriptor to
// the ingress pointer FIFO. A frame that starts under backpressure is
// dropped whole.
//
// Ports
//   clk                    in   single rising-edge clock
//   rstn                   in   asynchronous reset, active HIGH (legacy name)
//   sof                    in   start of frame, qualified by dv on byte0
//   dv                     in   byte valid, high across the contiguous frame
//   din[7:0]               in   frame byte
//   i_cell_data_fifo_dout  out  cell data, byte k at [127-8k -: 8]
//   i_cell_data_fifo_wr    out  one-cycle cell write strobe
//   i_cell_ptr_fifo_dout   out  {portmap, 4'b0000, cell_cnt_m1}
//   i_cell_ptr_fifo_wr     out  one-cycle descriptor write strobe
//   i_cell_bp              in   FIFO backpressure, sampled at frame start
module switch_pre (
    input  logic         clk,
    input  logic         rstn,
    input  logic         sof,
    input  logic         dv,
    input  logic [7:0]   din,
    output logic [127:0] i_cell_data_fifo_dout,
    output logic         i_cell_data_fifo_wr,
    output logic [15:0]  i_cell_ptr_fifo_dout,
    output logic         i_cell_ptr_fifo_wr,
    input  logic         i_cell_bp
);

    localparam int unsigned CELL_W  = 128;
    localparam int unsigned DESC_W  = 16;
    localparam int unsigned CNT_W   = 12;
    localparam int unsigned SLOTS   = 16;
    localparam int unsigned ST_W    = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_RECV  = 3'd1;
    localparam logic [ST_W-1:0] ST_FLUSH = 3'd2;
    localparam logic [ST_W-1:0] ST_PTR   = 3'd3;
    localparam logic [ST_W-1:0] ST_DROP  = 3'd4;

    logic [ST_W-1:0]   state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;      // bytes received, modulo 4096
    logic              sat_q, sat_d;      // 4096 bytes reached; ignore the rest
    logic [3:0]        pm_q, pm_d;
    logic [CELL_W-1:0] buf_q, buf_d;
    logic [CELL_W-1:0] cell_q, cell_d;
    logic              cell_wr_q, cell_wr_d;
    logic [DESC_W-1:0] desc_q, desc_d;
    logic              desc_wr_q, desc_wr_d;

    logic [3:0]        slot;
    logic [CELL_W-1:0] buf_ins;
    logic [7:0]        cells_m1;
    logic [DESC_W-1:0] desc_val;

    // Current byte slot in the cell and the buffer with din placed there.
    always_comb begin
        slot    = cnt_q[3:0];
        buf_ins = buf_q;
        for (int k = 0; k < int'(SLOTS); k++) begin
            if (slot == 4'(k)) begin
                buf_ins[CELL_W-1-8*k -: 8] = din;
            end
        end
    end

    // Descriptor from the byte count; a saturated count always reports 255.
    always_comb begin
        cells_m1 = sat_q ? 8'hFF : 8'((cnt_q - CNT_W'(1)) >> 4);
        desc_val = {pm_q, 4'b0000, cells_m1};
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        pm_d      = pm_q;
        buf_d     = buf_q;
        cell_d    = cell_q;
        cell_wr_d = 1'b0;
        desc_d    = desc_q;
        desc_wr_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sof && dv) begin
                    sat_d = 1'b0;
                    if (i_cell_bp) begin
                        cnt_d   = '0;
                        buf_d   = '0;
                        state_d = ST_DROP;
                    end else begin
                        pm_d    = din[3:0];
                        buf_d   = {din, (CELL_W-8)'(0)};
                        cnt_d   = CNT_W'(1);
                        state_d = ST_RECV;
                    end
                end
            end

            ST_RECV: begin
                if (dv) begin
                    if (!sat_q) begin
                        buf_d = buf_ins;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (slot == 4'd15) begin
                            cell_d    = buf_ins;
                            cell_wr_d = 1'b1;
                            buf_d     = '0;
                        end
                        if (cnt_q == {CNT_W{1'b1}}) begin
                            sat_d = 1'b1;
                        end
                    end
                end else if (slot != 4'd0) begin
                    // Partial last cell goes out now; descriptor follows.
                    cell_d    = buf_q;
                    cell_wr_d = 1'b1;
                    state_d   = ST_FLUSH;
                end else begin
                    // Last cell was already full, so the descriptor goes
                    // out right behind it.
                    desc_d    = desc_val;
                    desc_wr_d = 1'b1;
                    state_d   = ST_PTR;
                end
            end

            ST_FLUSH: begin
                desc_d    = desc_val;
                desc_wr_d = 1'b1;
                buf_d     = '0;
                state_d   = ST_PTR;
            end

            ST_PTR: begin
                state_d = ST_IDLE;
            end

            ST_DROP: begin
                if (!dv) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            pm_q      <= '0;
            buf_q     <= '0;
            cell_q    <= '0;
            cell_wr_q <= 1'b0;
            desc_q    <= '0;
            desc_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            pm_q      <= pm_d;
            buf_q     <= buf_d;
            cell_q    <= cell_d;
            cell_wr_q <= cell_wr_d;
            desc_q    <= desc_d;
            desc_wr_q <= desc_wr_d;
        end
    end

    assign i_cell_data_fifo_dout = cell_q;
    assign i_cell_data_fifo_wr   = cell_wr_q;
    assign i_cell_ptr_fifo_dout  = desc_q;
    assign i_cell_ptr_fifo_wr    = desc_wr_q;

endmodule

// File: tb/tb_switch_pre.sv
// tb_switch_pre: directed bench for switch_pre.
module tb_switch_pre;

    logic         clk = 1'b0;
    logic         rstn;
    logic         sof;
    logic         dv;
    logic [7:0]   din;
    logic         i_cell_bp;
    logic [127:0] i_cell_data_fifo_dout;
    logic         i_cell_data_fifo_wr;
    logic [15:0]  i_cell_ptr_fifo_dout;
    logic         i_cell_ptr_fifo_wr;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int overlap = 0;
    int byte15_cyc = 0;
    int dv0_cyc = 0;

    logic [127:0] cell_q[$];
    int           cell_cyc[$];
    logic [15:0]  desc_q[$];
    int           desc_cyc[$];

    switch_pre dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .sof                   (sof),
        .dv                    (dv),
        .din                   (din),
        .i_cell_data_fifo_dout (i_cell_data_fifo_dout),
        .i_cell_data_fifo_wr   (i_cell_data_fifo_wr),
        .i_cell_ptr_fifo_dout  (i_cell_ptr_fifo_dout),
        .i_cell_ptr_fifo_wr    (i_cell_ptr_fifo_wr),
        .i_cell_bp             (i_cell_bp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write with the cycle it was seen in.
    always @(negedge clk) begin
        if (i_cell_data_fifo_wr) begin
            cell_q.push_back(i_cell_data_fifo_dout);
            cell_cyc.push_back(cyc);
        end
        if (i_cell_ptr_fifo_wr) begin
            desc_q.push_back(i_cell_ptr_fifo_dout);
            desc_cyc.push_back(cyc);
        end
        if (i_cell_data_fifo_wr && i_cell_ptr_fifo_wr) overlap++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] frame_byte(input int len, input int k, input logic [3:0] pm);
        logic [11:0] l;
        l = 12'(len);
        if (k == 0)      return {l[11:8], pm};
        else if (k == 1) return l[7:0];
        else             return 8'(k);
    endfunction

    function automatic logic [127:0] exp_cell(input int len, input logic [3:0] pm, input int c);
        logic [127:0] v;
        v = '0;
        for (int j = 0; j < 16; j++) begin
            if (c * 16 + j < len) v[127-8*j -: 8] = frame_byte(len, c * 16 + j, pm);
        end
        return v;
    endfunction

    task automatic clear_q();
        cell_q.delete();
        cell_cyc.delete();
        desc_q.delete();
        desc_cyc.delete();
    endtask

    // Entered and left #1 after a rising edge.
    task automatic send_frame(input int len, input logic [3:0] pm, input logic bp);
        for (int k = 0; k < len; k++) begin
            sof       = (k == 0);
            dv        = 1'b1;
            din       = frame_byte(len, k, pm);
            i_cell_bp = bp;
            if (k == 15) byte15_cyc = cyc;
            @(posedge clk);
            #1;
        end
        sof       = 1'b0;
        dv        = 1'b0;
        din       = '0;
        i_cell_bp = 1'b0;
        dv0_cyc   = cyc;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input int len, input logic [3:0] pm,
                               input logic [15:0] exp_desc, input int cbase, input int didx);
        int n;
        n = (len + 15) / 16;
        for (int c = 0; c < n; c++) begin
            chk($sformatf("%s_cell%0d", tag, c), cell_q[cbase + c], exp_cell(len, pm, c));
        end
        chk({tag, "_desc"}, 128'(desc_q[didx]), 128'(exp_desc));
        chk({tag, "_ptr_lat"}, 128'(desc_cyc[didx]), 128'(cell_cyc[cbase + n - 1] + 1));
    endtask

    initial begin
        rstn = 1'b1;
        sof = 1'b0;
        dv = 1'b0;
        din = '0;
        i_cell_bp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", i_cell_data_fifo_dout, 128'h0);
        chk("rst_wr", 128'(i_cell_data_fifo_wr), 128'h0);
        chk("rst_pdout", 128'(i_cell_ptr_fifo_dout), 128'h0);
        chk("rst_pwr", 128'(i_cell_ptr_fifo_wr), 128'h0);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Three frames back to back with 100 ns gaps.
        clear_q();
        send_frame(128, 4'h1, 1'b0);
        chk("f128_cells", 128'(cell_q.size()), 128'd8);
        chk("f128_c0_head", 128'(cell_q[0][127:104]), 128'h018002);
        chk("f128_c7_tail", 128'(cell_q[7][7:0]), 128'h7F);
        chk("f128_cell_lat", 128'(cell_cyc[0]), 128'(byte15_cyc + 1));
        check_frame("f128", 128, 4'h1, 16'h1007, 0, 0);
        send_frame(256, 4'h1, 1'b0);
        chk("f256_c0_head", 128'(cell_q[8][127:104]), 128'h110002);
        check_frame("f256", 256, 4'h1, 16'h100F, 8, 1);
        send_frame(64, 4'h1, 1'b0);
        check_frame("f64", 64, 4'h1, 16'h1003, 24, 2);
        chk("b2b_cells", 128'(cell_q.size()), 128'd28);
        chk("b2b_descs", 128'(desc_q.size()), 128'd3);
        chk("b2b_d0", 128'(desc_q[0]), 128'h1007);
        chk("b2b_d1", 128'(desc_q[1]), 128'h100F);
        chk("b2b_d2", 128'(desc_q[2]), 128'h1003);

        // Partial final cell.
        clear_q();
        send_frame(20, 4'hA, 1'b0);
        chk("f20_cells", 128'(cell_q.size()), 128'd2);
        chk("f20_c1", cell_q[1], {32'h10111213, 96'h0});
        chk("f20_part_lat", 128'(cell_cyc[1]), 128'(dv0_cyc + 1));
        check_frame("f20", 20, 4'hA, 16'hA001, 0, 0);

        // Backpressure at frame start drops the frame; next one goes through.
        clear_q();
        send_frame(64, 4'h1, 1'b1);
        chk("bp_cells", 128'(cell_q.size()), 128'd0);
        chk("bp_descs", 128'(desc_q.size()), 128'd0);
        send_frame(64, 4'h1, 1'b0);
        chk("after_bp_cells", 128'(cell_q.size()), 128'd4);
        check_frame("after_bp", 64, 4'h1, 16'h1003, 0, 0);

        // Oversized frame: count saturates, descriptor reports 255.
        clear_q();
        send_frame(4100, 4'h3, 1'b0);
        chk("big_cells", 128'(cell_q.size()), 128'd256);
        chk("big_c255", cell_q[255], exp_cell(4100, 4'h3, 255));
        chk("big_desc", 128'(desc_q[0]), 128'h30FF);

        // Reset in the middle of a frame.
        clear_q();
        for (int k = 0; k < 40; k++) begin
            sof = (k == 0);
            dv  = 1'b1;
            din = frame_byte(64, k, 4'h1);
            @(posedge clk);
            #1;
        end
        #2;
        rstn = 1'b1;
        #1;
        chk("mid_rst_wr", 128'(i_cell_data_fifo_wr), 128'h0);
        chk("mid_rst_pwr", 128'(i_cell_ptr_fifo_wr), 128'h0);
        chk("mid_rst_dout", i_cell_data_fifo_dout, 128'h0);
        chk("mid_rst_pre_cells", 128'(cell_q.size()), 128'd2);
        for (int k = 40; k < 50; k++) begin
            @(posedge clk);
            #1;
            sof = 1'b0;
            din = frame_byte(64, k, 4'h1);
            if (k == 45) rstn = 1'b0;
        end
        @(posedge clk);
        #1;
        dv  = 1'b0;
        din = '0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rst_cells", 128'(cell_q.size()), 128'd2);
        chk("mid_rst_descs", 128'(desc_q.size()), 128'd0);
        clear_q();
        send_frame(64, 4'h1, 1'b0);
        chk("post_rst_cells", 128'(cell_q.size()), 128'd4);
        check_frame("post_rst", 64, 4'h1, 16'h1003, 0, 0);

        chk("no_overlap", 128'(overlap), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
